// File: rtl/indexed_rsh_pkg.sv
// Shared constants, types and helpers for the 1-to-4 stream demultiplexer.
package indexed_rsh_pkg;

  localparam int N_LANES    = 4;
  localparam int LANE_DEPTH = 2;

  // Per-lane occupancy: 0, 1 or 2 entries.
  typedef logic [1:0] lane_count_t;

  localparam lane_count_t LANE_EMPTY = 2'd0;
  localparam lane_count_t LANE_FULL  = 2'd2;

  // A lane can take a new beat only when it is not holding two entries.
  function automatic logic lane_has_room(input lane_count_t count);
    return (count != LANE_FULL);
  endfunction

  // A lane presents a beat whenever it holds at least one entry.
  function automatic logic lane_has_data(input lane_count_t count);
    return (count != LANE_EMPTY);
  endfunction

endpackage

// File: rtl/demux_lane_fifo.sv
// Two-entry FIFO used as the buffer behind one demux output lane.
// The head entry is driven out directly; dout reads as zero when empty.
module demux_lane_fifo
  import indexed_rsh_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output lane_count_t       count
);

  lane_count_t       r_count;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [DATA_W-1:0] r_mem [LANE_DEPTH];

  logic              w_push_ok;
  logic              w_pop_ok;
  lane_count_t       w_count_nxt;

  // Qualify push/pop against occupancy and work out the next count.
  always_comb begin
    w_push_ok   = push && lane_has_room(r_count);
    w_pop_ok    = pop && lane_has_data(r_count);
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Occupancy and 1-bit wrap-around pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= LANE_EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push_ok) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Storage; cleared on reset so no stale payload survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= {DATA_W{1'b0}};
      r_mem[1] <= {DATA_W{1'b0}};
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  assign count = r_count;
  assign dout  = lane_has_data(r_count) ? r_mem[r_rd_ptr] : {DATA_W{1'b0}};

endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a 2-entry FIFO per lane.
// in_ready comes from registered lane occupancy only, never from out_ready.
module demux_1_4_stream
  import indexed_rsh_pkg::*;
#(
  parameter int data_width_param = 32,
  parameter int sel_width_param  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [data_width_param-1:0] in_data,
  input  logic [sel_width_param-1:0]  in_sel,
  output logic [N_LANES-1:0]          out_valid,
  input  logic [N_LANES-1:0]          out_ready,
  output logic [data_width_param-1:0] out_data0,
  output logic [data_width_param-1:0] out_data1,
  output logic [data_width_param-1:0] out_data2,
  output logic [data_width_param-1:0] out_data3
);

  lane_count_t                 w_count [N_LANES];
  logic [data_width_param-1:0] w_dout  [N_LANES];
  logic [N_LANES-1:0]          w_push_oh;
  logic [N_LANES-1:0]          w_pop;

  // Readiness of the addressed lane, from its registered occupancy.
  always_comb begin
    in_ready = lane_has_room(w_count[in_sel]);
  end

  // One-hot push toward the addressed lane on an accepted beat.
  always_comb begin
    w_push_oh = 4'b0000;
    if (in_valid && in_ready) begin
      w_push_oh = 4'b0001 << in_sel;
    end else begin
      w_push_oh = 4'b0000;
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    assign out_valid[g] = lane_has_data(w_count[g]);
    assign w_pop[g]     = out_valid[g] && out_ready[g];

    demux_lane_fifo #(
      .DATA_W (data_width_param)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push_oh[g]),
      .pop   (w_pop[g]),
      .din   (in_data),
      .dout  (w_dout[g]),
      .count (w_count[g])
    );
  end

  assign out_data0 = w_dout[0];
  assign out_data1 = w_dout[1];
  assign out_data2 = w_dout[2];
  assign out_data3 = w_dout[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: per-lane scoreboard queues plus
// scenario tasks with their own targeted checks.
module tb_demux_1_4_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [31:0] od [4];

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;
  int pops [4];

  logic [31:0] sb [4][$];

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  always #5 clk = ~clk;

  demux_1_4_stream #(
    .data_width_param (32),
    .sel_width_param  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
  );

  // Scoreboard monitor: on each falling edge compare the DUT against the
  // model, then apply the pops/pushes the coming rising edge will perform.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic       exp_rdy;
      logic [3:0] do_pop;
      exp_rdy = (sb[in_sel].size() != 2);
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_errors++;
        $display("FAIL mon_in_ready sel %0d: got %b expected %b", in_sel, in_ready, exp_rdy);
      end
      for (int k = 0; k < 4; k++) begin
        logic        ev;
        logic [31:0] ed;
        ev = (sb[k].size() != 0);
        ed = ev ? sb[k][0] : 32'h0;
        n_checks++;
        if (out_valid[k] !== ev) begin
          n_errors++;
          $display("FAIL mon_out_valid lane %0d: got %b expected %b", k, out_valid[k], ev);
        end
        n_checks++;
        if (od[k] !== ed) begin
          n_errors++;
          $display("FAIL mon_out_data lane %0d: got %h expected %h", k, od[k], ed);
        end
        do_pop[k] = ev && out_ready[k];
      end
      for (int k = 0; k < 4; k++) begin
        if (do_pop[k]) begin
          void'(sb[k].pop_front());
          pops[k]++;
        end
      end
      if (in_valid && exp_rdy) begin
        sb[in_sel].push_back(in_data);
      end
    end
  end

  // Apply inputs, then advance to just after the next rising edge.
  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 32'h55;
    out_ready = 4'b0000;
    #2;
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_out_valid: got %b expected 0000", out_valid);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (od[k] !== 32'h0) begin
        n_errors++;
        $display("FAIL reset_out_data lane %0d: got %h expected 0", k, od[k]);
      end
    end
    #1;
    rst_n = 1'b1;
    sb[0].push_back(32'h55);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b0001 || out_data0 !== 32'h55) begin
      n_errors++;
      $display("FAIL reset_first_push: got valid %b data %h expected 0001 00000055",
               out_valid, out_data0);
    end
    mon_en = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 32'h0, 4'b1111);
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_errors++;
      $display("FAIL drain_out_valid: got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_routing();
    for (int k = 0; k < 4; k++) drive(1'b1, 2'(k), 32'hA0 + 32'(k), 4'b0000);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 4'b1111) begin
      n_errors++;
      $display("FAIL routing_out_valid: got %b expected 1111", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (od[k] !== 32'hA0 + 32'(k)) begin
        n_errors++;
        $display("FAIL routing_out_data lane %0d: got %h expected %h", k, od[k], 32'hA0 + 32'(k));
      end
    end
  endtask

  task automatic test_full_lane();
    drive(1'b1, 2'd2, 32'h11, 4'b0000);
    drive(1'b1, 2'd2, 32'h22, 4'b0000);
    in_data = 32'h33;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL full_in_ready_lane2: got %b expected 0", in_ready);
    end
    in_sel  = 2'd1;
    in_data = 32'h44;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL full_in_ready_lane1: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b0110 || out_data2 !== 32'h11 || out_data1 !== 32'h44) begin
      n_errors++;
      $display("FAIL full_state: got valid %b d2 %h d1 %h expected 0110 11 44",
               out_valid, out_data2, out_data1);
    end
  endtask

  task automatic test_streaming();
    int start;
    start = pops[3];
    for (int i = 0; i < 100; i++) drive(1'b1, 2'd3, 32'(i), 4'b1000);
    drive(1'b0, 2'd3, 32'h0, 4'b1000);
    drive(1'b0, 2'd3, 32'h0, 4'b1000);
    n_checks++;
    if (pops[3] - start != 100) begin
      n_errors++;
      $display("FAIL stream_count: got %0d expected 100", pops[3] - start);
    end
  endtask

  task automatic test_push_pop_count1();
    drive(1'b1, 2'd0, 32'hB0, 4'b0000);
    drive(1'b1, 2'd0, 32'hB1, 4'b0001);
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b1 || out_data0 !== 32'hB1) begin
      n_errors++;
      $display("FAIL pushpop_count1: got valid %b data %h expected 1 b1", out_valid[0], out_data0);
    end
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 2'd0, 32'hC0, 4'b0000);
    drive(1'b1, 2'd0, 32'hC1, 4'b0000);
    drive(1'b1, 2'd1, 32'hC2, 4'b0000);
    drive(1'b1, 2'd3, 32'hC3, 4'b0000);
    drive(1'b1, 2'd3, 32'hC4, 4'b0000);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b1011) begin
      n_errors++;
      $display("FAIL midrst_setup: got %b expected 1011", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_immediate: got valid %b ready %b expected 0000 1", out_valid, in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      sb[k].delete();
      n_checks++;
      if (od[k] !== 32'h0) begin
        n_errors++;
        $display("FAIL midrst_out_data lane %0d: got %h expected 0", k, od[k]);
      end
    end
    #1;
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 4'b1111);
    drive(1'b1, 2'd3, 32'hD0, 4'b0000);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b1000 || out_data3 !== 32'hD0) begin
      n_errors++;
      $display("FAIL midrst_after: got valid %b d3 %h expected 1000 d0", out_valid, out_data3);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) pops[k] = 0;
    test_reset();
    drain();
    test_routing();
    drain();
    test_full_lane();
    drain();
    test_streaming();
    drain();
    test_push_pop_count1();
    drain();
    test_mid_reset();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
